paint_cursor_ctrl: RTL and testbench

//  Sequencer between the joystick sampler and the VGA canvas framebuffer. Turns each

---
 rtl/paint_cursor_ctrl.sv | 164 ++++++++++++++++
 tb/tb_paint_cursor_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paint_cursor_ctrl.sv
// Joystick-driven cursor stepper issuing single-pixel paint writes or a full-canvas clear sweep.
// Sample in IDLE -> fb_req/cursor update two cycles later; fb_req holds address/data until fb_gnt.
module paint_cursor_ctrl #(
  parameter int              CANVAS_W = 160,
  parameter int              CANVAS_H = 120,
  parameter int              XW       = 8,
  parameter int              YW       = 7,
  parameter int              AW       = 15,
  parameter int              CENTER   = 512,
  parameter int              DEADZONE = 100,
  parameter logic [2:0]      BG_COLOR = 3'd0
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          js_valid,
  input  logic [9:0]    js_x,
  input  logic [9:0]    js_y,
  input  logic [2:0]    js_btn,
  input  logic [2:0]    color,
  output logic          fb_req,
  input  logic          fb_gnt,
  output logic [AW-1:0] fb_addr,
  output logic [2:0]    fb_wdata,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, MOVE, PAINT, CLEAR} state_t;

  localparam logic [10:0]   HI_TH     = 11'(CENTER + DEADZONE);
  localparam logic [10:0]   LO_TH     = 11'(CENTER - DEADZONE);
  localparam logic [XW-1:0] X_MAX     = XW'(CANVAS_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(CANVAS_H - 1);
  localparam logic [AW-1:0] ROW_PITCH = AW'(CANVAS_W);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CANVAS_W * CANVAS_H - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] cur_x_q, cur_x_d, new_x;
  logic [YW-1:0] cur_y_q, cur_y_d, new_y;
  logic [9:0]    js_x_q, js_x_d, js_y_q, js_y_d;
  logic          pen_q, pen_d, hist_q, hist_d;
  logic [2:0]    color_q, color_d, fb_wdata_q, fb_wdata_d;
  logic          fb_req_q, fb_req_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d, paint_addr;
  logic          unused_btn;

  assign unused_btn = js_btn[2];

  // Saturating one-pixel step from the latched sample; stick up moves toward row 0.
  always_comb begin
    new_x = cur_x_q;
    new_y = cur_y_q;
    if (({1'b0, js_x_q} > HI_TH) && (cur_x_q != X_MAX)) begin
      new_x = cur_x_q + XW'(1);
    end else if (({1'b0, js_x_q} < LO_TH) && (cur_x_q != '0)) begin
      new_x = cur_x_q - XW'(1);
    end
    if (({1'b0, js_y_q} > HI_TH) && (cur_y_q != '0)) begin
      new_y = cur_y_q - YW'(1);
    end else if (({1'b0, js_y_q} < LO_TH) && (cur_y_q != Y_MAX)) begin
      new_y = cur_y_q + YW'(1);
    end
    paint_addr = AW'(new_y) * ROW_PITCH + AW'(new_x);
  end

  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    js_x_d     = js_x_q;
    js_y_d     = js_y_q;
    pen_d      = pen_q;
    hist_d     = hist_q;
    color_d    = color_q;
    fb_req_d   = fb_req_q;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    case (state_q)
      IDLE: begin
        if (js_valid) begin
          js_x_d  = js_x;
          js_y_d  = js_y;
          pen_d   = js_btn[0];
          color_d = color;
          hist_d  = js_btn[1];
          if (js_btn[1] && !hist_q) begin
            state_d    = CLEAR;
            fb_req_d   = 1'b1;
            fb_addr_d  = '0;
            fb_wdata_d = BG_COLOR;
          end else begin
            state_d = MOVE;
          end
        end
      end
      MOVE: begin
        cur_x_d = new_x;
        cur_y_d = new_y;
        if (pen_q) begin
          state_d    = PAINT;
          fb_req_d   = 1'b1;
          fb_addr_d  = paint_addr;
          fb_wdata_d = color_q;
        end else begin
          state_d = IDLE;
        end
      end
      PAINT: begin
        if (fb_gnt) begin
          fb_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      CLEAR: begin
        if (fb_gnt) begin
          if (fb_addr_q == LAST_ADDR) begin
            fb_req_d = 1'b0;
            state_d  = IDLE;
          end else begin
            fb_addr_d = fb_addr_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      cur_x_q    <= XW'(CANVAS_W / 2);
      cur_y_q    <= YW'(CANVAS_H / 2);
      js_x_q     <= '0;
      js_y_q     <= '0;
      pen_q      <= 1'b0;
      hist_q     <= 1'b0;
      color_q    <= '0;
      fb_req_q   <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      js_x_q     <= js_x_d;
      js_y_q     <= js_y_d;
      pen_q      <= pen_d;
      hist_q     <= hist_d;
      color_q    <= color_d;
      fb_req_q   <= fb_req_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
    end
  end

  assign fb_req   = fb_req_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_paint_cursor_ctrl.sv
// Randomized bench for paint_cursor_ctrl against a plain-arithmetic cursor/write model.
module tb_paint_cursor_ctrl;
  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        js_valid = 1'b0;
  logic [9:0]  js_x = 10'd512;
  logic [9:0]  js_y = 10'd512;
  logic [2:0]  js_btn = 3'd0;
  logic [2:0]  color = 3'd0;
  logic        fb_gnt = 1'b0;
  logic        fb_req;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic [7:0]  cur_x;
  logic [6:0]  cur_y;
  logic        busy;

  paint_cursor_ctrl dut (
    .clk(clk), .clr_n(clr_n), .js_valid(js_valid), .js_x(js_x), .js_y(js_y),
    .js_btn(js_btn), .color(color), .fb_req(fb_req), .fb_gnt(fb_gnt),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int gnt_mode = 0;  // 0 low, 1 high, 2 random, 3 driven by the test
  int req_seen = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];

  int mx = 80;
  int my = 60;
  bit mhist = 1'b0;

  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      0: fb_gnt = 1'b0;
      1: fb_gnt = 1'b1;
      2: fb_gnt = 1'($urandom % 2);
      default: ;
    endcase
  end

  always @(negedge clk) begin : monitor
    wr_t w;
    if (clr_n) begin
      if (fb_req) req_seen++;
      if (fb_req && fb_gnt) begin
        w.addr = int'(fb_addr);
        w.data = int'(fb_wdata);
        got_q.push_back(w);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    mx = W / 2;
    my = H / 2;
    mhist = 1'b0;
  endfunction

  function automatic void model_sample(int x, int y, logic [2:0] btn, int col);
    wr_t w;
    bit rising;
    rising = btn[1] && !mhist;
    mhist = btn[1];
    if (rising) begin
      for (int i = 0; i < W * H; i++) begin
        w.addr = i;
        w.data = 0;
        exp_q.push_back(w);
      end
    end else begin
      if (x > 612 && mx < W - 1) mx++;
      else if (x < 412 && mx > 0) mx--;
      if (y > 612 && my > 0) my--;
      else if (y < 412 && my < H - 1) my++;
      if (btn[0]) begin
        w.addr = my * W + mx;
        w.data = col;
        exp_q.push_back(w);
      end
    end
  endfunction

  task automatic send(input int x, input int y, input logic [2:0] btn, input int col);
    @(posedge clk); #1;
    js_valid = 1'b1;
    js_x = 10'(x);
    js_y = 10'(y);
    js_btn = btn;
    color = 3'(col);
    @(posedge clk); #1;
    js_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    gnt_mode = 1;
    model_reset();
    #23;
    total++; if (cur_x !== 8'd80 || cur_y !== 7'd60) begin bad++; $display("FAIL reset_cur got=(%0d,%0d) exp=(80,60)", cur_x, cur_y); end
    total++; if (fb_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_req_busy got=%b%b exp=00", fb_req, busy); end
    total++; if (fb_addr !== 15'd0 || fb_wdata !== 3'd0) begin bad++; $display("FAIL reset_addr_data got=%0d/%0d exp=0/0", fb_addr, fb_wdata); end
    @(negedge clk); clr_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (fb_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b%b exp=00", fb_req, busy); end
  endtask

  task automatic test_paint_directed();
    bit ok;
    gnt_mode = 1;
    got_q.delete(); exp_q.delete();
    model_sample(900, 512, 3'b001, 5);
    send(900, 512, 3'b001, 5);
    @(negedge clk);
    total++; if (fb_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL latency_n1 req/busy got=%b%b exp=01", fb_req, busy); end
    @(negedge clk);
    total++; if (fb_req !== 1'b1 || cur_x !== 8'd81 || cur_y !== 7'd60) begin bad++; $display("FAIL latency_n2 req=%b cur=(%0d,%0d) exp req=1 cur=(81,60)", fb_req, cur_x, cur_y); end
    total++; if (fb_addr !== 15'd9681 || fb_wdata !== 3'd5) begin bad++; $display("FAIL paint_addr got=%0d/%0d exp=9681/5", fb_addr, fb_wdata); end
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL paint_idle_timeout busy=%b exp=0", busy); end
    total++; if (got_q.size() != 1 || got_q[0].addr != 9681 || got_q[0].data != 5) begin bad++; $display("FAIL paint_commit got n=%0d exp n=1 addr=9681 data=5", got_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int x, y, col, req0;
    logic [2:0] btn;
    int tbl[10] = '{0, 100, 411, 412, 511, 512, 612, 613, 700, 1023};
    gnt_mode = 2;
    for (int it = 0; it < 60; it++) begin
      x = ($urandom % 2) ? tbl[$urandom % 10] : int'($urandom % 1024);
      y = ($urandom % 2) ? tbl[$urandom % 10] : int'($urandom % 1024);
      btn = {1'($urandom % 2), 1'b0, 1'($urandom % 2)};
      col = int'($urandom % 8);
      got_q.delete(); exp_q.delete();
      req0 = req_seen;
      model_sample(x, y, btn, col);
      send(x, y, btn, col);
      wait_idle(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_timeout it=%0d", it); end
      total++; if (int'(cur_x) != mx || int'(cur_y) != my) begin bad++; $display("FAIL rand_cur it=%0d got=(%0d,%0d) exp=(%0d,%0d)", it, cur_x, cur_y, mx, my); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_nwrites it=%0d got=%0d exp=%0d", it, got_q.size(), exp_q.size()); end
      else if (exp_q.size() == 1) begin
        total++; if (got_q[0].addr != exp_q[0].addr || got_q[0].data != exp_q[0].data) begin bad++; $display("FAIL rand_write it=%0d got=%0d/%0d exp=%0d/%0d", it, got_q[0].addr, got_q[0].data, exp_q[0].addr, exp_q[0].data); end
      end
      if (!btn[0]) begin
        total++; if (req_seen != req0) begin bad++; $display("FAIL rand_penup_req it=%0d req_cycles=%0d exp=0", it, req_seen - req0); end
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    int req0;
    gnt_mode = 1;
    for (int i = 0; i < 170; i++) begin
      model_sample(1000, 1000, 3'b000, 0);
      send(1000, 1000, 3'b000, 0);
      wait_idle(20, ok);
    end
    total++; if (cur_x !== 8'd159 || cur_y !== 7'd0) begin bad++; $display("FAIL sat_reach got=(%0d,%0d) exp=(159,0)", cur_x, cur_y); end
    req0 = req_seen;
    for (int i = 0; i < 3; i++) begin
      model_sample(1000, 1000, 3'b000, 0);
      send(1000, 1000, 3'b000, 0);
      wait_idle(20, ok);
      total++; if (!ok || cur_x !== 8'd159 || cur_y !== 7'd0) begin bad++; $display("FAIL sat_hold i=%0d got=(%0d,%0d) exp=(159,0)", i, cur_x, cur_y); end
    end
    total++; if (req_seen != req0) begin bad++; $display("FAIL sat_req got=%0d exp=0", req_seen - req0); end
  endtask

  task automatic test_deadzone();
    bit ok;
    int req0;
    gnt_mode = 1;
    req0 = req_seen;
    model_sample(600, 420, 3'b000, 3);
    send(600, 420, 3'b000, 3);
    wait_idle(20, ok);
    total++; if (!ok || int'(cur_x) != mx || int'(cur_y) != my || cur_x !== 8'd159) begin bad++; $display("FAIL dead_nomove got=(%0d,%0d) exp=(%0d,%0d)", cur_x, cur_y, mx, my); end
    total++; if (req_seen != req0) begin bad++; $display("FAIL dead_penup_req got=%0d exp=0", req_seen - req0); end
    got_q.delete(); exp_q.delete();
    model_sample(600, 420, 3'b001, 4);
    send(600, 420, 3'b001, 4);
    wait_idle(20, ok);
    total++; if (got_q.size() != 1 || got_q[0].addr != 159 || got_q[0].data != 4) begin bad++; $display("FAIL dead_pendown n=%0d exp n=1 addr=159 data=4", got_q.size()); end
  endtask

  task automatic test_stall();
    bit ok;
    int a0, d0;
    gnt_mode = 0;
    got_q.delete(); exp_q.delete();
    model_sample(512, 300, 3'b001, 6);
    send(512, 300, 3'b001, 6);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fb_req) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL stall_req_timeout req=%b exp=1", fb_req); end
    a0 = int'(fb_addr); d0 = int'(fb_wdata);
    total++; if (a0 != exp_q[0].addr || d0 != 6) begin bad++; $display("FAIL stall_addr got=%0d/%0d exp=%0d/6", a0, d0, exp_q[0].addr); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      js_valid = (i == 5);
      js_x = 10'd0; js_y = 10'd1023; js_btn = 3'b011;
      total++; if (fb_req !== 1'b1 || int'(fb_addr) != a0 || int'(fb_wdata) != d0) begin bad++; $display("FAIL stall_stable i=%0d got req=%b %0d/%0d exp 1 %0d/%0d", i, fb_req, fb_addr, fb_wdata, a0, d0); end
    end
    gnt_mode = 3;
    @(negedge clk); fb_gnt = 1'b1; js_valid = 1'b1;
    @(negedge clk); fb_gnt = 1'b0; js_valid = 1'b0; js_btn = 3'b000;
    wait_idle(20, ok);
    repeat (3) @(negedge clk);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL stall_commits got=%0d exp=1", got_q.size()); end
    total++; if (busy !== 1'b0 || fb_req !== 1'b0) begin bad++; $display("FAIL stall_drop busy/req got=%b%b exp=00", busy, fb_req); end
    total++; if (int'(cur_x) != mx || int'(cur_y) != my) begin bad++; $display("FAIL stall_cur got=(%0d,%0d) exp=(%0d,%0d)", cur_x, cur_y, mx, my); end
  endtask

  task automatic test_clear();
    bit ok;
    int nerr, req0;
    gnt_mode = 2;
    got_q.delete(); exp_q.delete();
    model_sample(512, 512, 3'b010, 0);
    send(512, 512, 3'b010, 0);
    wait_idle(60000, ok);
    total++; if (!ok) begin bad++; $display("FAIL clear_timeout busy=%b exp=0", busy); end
    total++; if (got_q.size() != W * H) begin bad++; $display("FAIL clear_count got=%0d exp=%0d", got_q.size(), W * H); end
    nerr = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i].addr != exp_q[i].addr || got_q[i].data != exp_q[i].data) begin
        bad++;
        if (nerr < 5) $display("FAIL clear_write i=%0d got=%0d/%0d exp=%0d/%0d", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
        nerr++;
      end
    end
    total++; if (int'(cur_x) != mx || int'(cur_y) != my || fb_req !== 1'b0) begin bad++; $display("FAIL clear_after cur=(%0d,%0d) req=%b exp=(%0d,%0d) 0", cur_x, cur_y, fb_req, mx, my); end
    got_q.delete(); exp_q.delete();
    req0 = req_seen;
    model_sample(512, 512, 3'b010, 0);
    send(512, 512, 3'b010, 0);
    wait_idle(10, ok);
    total++; if (!ok || got_q.size() != 0 || req_seen != req0) begin bad++; $display("FAIL clear_held ok=%0d writes=%0d req_cycles=%0d exp 1/0/0", ok, got_q.size(), req_seen - req0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    gnt_mode = 0;
    send(512, 512, 3'b001, 2);
    repeat (4) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    total++; if (fb_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_drop req/busy got=%b%b exp=00", fb_req, busy); end
    total++; if (cur_x !== 8'd80 || cur_y !== 7'd60) begin bad++; $display("FAIL midreset_cur got=(%0d,%0d) exp=(80,60)", cur_x, cur_y); end
    model_reset();
    @(negedge clk); clr_n = 1'b1;
    gnt_mode = 1;
    got_q.delete(); exp_q.delete();
    model_sample(900, 512, 3'b001, 1);
    send(900, 512, 3'b001, 1);
    wait_idle(20, ok);
    total++; if (!ok || got_q.size() != 1 || got_q[0].addr != 9681 || got_q[0].data != 1) begin bad++; $display("FAIL midreset_recover n=%0d exp n=1 addr=9681 data=1", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_paint_directed();
    test_random();
    test_saturation();
    test_deadzone();
    test_stall();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
